// File: rtl/mult8_accumulator_pkg.sv
// Shared mult8 datapath definitions: product width, default accumulator and
// counter widths, and the accumulator FSM state type.
package mult8_pkg;

  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/mult8_accumulator_if.sv
// Product-in / frame-result-out handshake bundle for mult8_accumulator.
// The master side is the producer/consumer environment; the slave side is the
// accumulator itself.
interface mult8_accumulator_if
  import mult8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;
  logic              acc_clr;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_product, in_last, acc_clr, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, acc_clr, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/mult8_accumulator_add.sv
// ACC_W-bit accumulate adder: acc + zero-extended product, with carry-out.
// Build option MULT8_ACC_SAT_EN: clamp the sum to all-ones on carry-out instead
// of wrapping. Once clamped, any further non-zero term carries again, so the
// clamp persists for the rest of the frame without extra state.
module mult8_acc_add
  import mult8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] raw;

`ifdef MULT8_ACC_SAT_EN
  function automatic logic [ACC_W-1:0] sat_clamp(input logic [ACC_W:0] r);
    return r[ACC_W] ? {ACC_W{1'b1}} : r[ACC_W-1:0];
  endfunction
`else
  function automatic logic [ACC_W-1:0] wrap_trunc(input logic [ACC_W:0] r);
    return r[ACC_W-1:0];
  endfunction
`endif

  // Widened add exposes the carry; result is clamped or wrapped by build option
  always_comb begin
    raw   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
    carry = raw[ACC_W];
`ifdef MULT8_ACC_SAT_EN
    sum   = sat_clamp(raw);
`else
    sum   = wrap_trunc(raw);
`endif
  end

endmodule

// File: rtl/mult8_accumulator.sv
// mult8_accumulator: sums a frame of 16-bit products (terminated by in_last)
// and presents sum, term count and sticky overflow on a valid/ready port.
// Build option MULT8_ACC_SAT_EN selects saturating instead of wrapping sums.
module mult8_accumulator
  import mult8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  mult8_accumulator_if.slave bus
);

  acc_state_t       state;
  logic [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0] count_p0;
  logic             ovf_p0;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             accept;
  logic             in_ready;
  logic             out_valid;

  mult8_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc     (acc_p0),
    .product (bus.in_product),
    .sum     (add_sum),
    .carry   (add_carry)
  );

  // Handshake decode from registered state; acc_clr blocks the input port
  always_comb begin
    in_ready  = (state == ACCUM) && !bus.acc_clr;
    out_valid = (state == HOLD);
    accept    = bus.in_valid && in_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = acc_p0;
  assign bus.out_count = count_p0;
  assign bus.out_ovf   = ovf_p0;

  // ---- accumulate stage: FSM, running sum, saturating term count, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      acc_p0   <= '0;
      count_p0 <= '0;
      ovf_p0   <= 1'b0;
    end else if (bus.acc_clr) begin
      state    <= ACCUM;
      acc_p0   <= '0;
      count_p0 <= '0;
      ovf_p0   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_p0 <= add_sum;
            ovf_p0 <= ovf_p0 | add_carry;
            if (count_p0 != {CNT_W{1'b1}}) begin
              count_p0 <= count_p0 + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (bus.in_last) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state    <= ACCUM;
            acc_p0   <= '0;
            count_p0 <= '0;
            ovf_p0   <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_accumulator.sv
// Bench for mult8_accumulator: a 24-bit and a 17-bit instance share one
// stimulus stream and are checked every cycle against an ideal-sum model.
// Honours MULT8_ACC_SAT_EN when computing expected sums.
module tb_mult8_accumulator;
  import mult8_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, acc_clr, out_ready;
  logic [15:0] in_product;

  int vectors     = 0;
  int miscompares = 0;

  // Model: exact (unbounded) frame sum, term count, result-pending flag
  longint m_sum  = 0;
  int     m_cnt  = 0;
  bit     m_hold = 1'b0;

  always #5 clk = ~clk;

  mult8_accumulator_if #(.ACC_W(24), .CNT_W(8)) bus24 ();
  mult8_accumulator_if #(.ACC_W(17), .CNT_W(8)) bus17 ();

  assign bus24.in_valid   = in_valid;
  assign bus24.in_product = in_product;
  assign bus24.in_last    = in_last;
  assign bus24.acc_clr    = acc_clr;
  assign bus24.out_ready  = out_ready;
  assign bus17.in_valid   = in_valid;
  assign bus17.in_product = in_product;
  assign bus17.in_last    = in_last;
  assign bus17.acc_clr    = acc_clr;
  assign bus17.out_ready  = out_ready;

  mult8_accumulator #(.ACC_W(24), .CNT_W(8)) dut24 (.clk(clk), .rst_n(rst_n), .bus(bus24));
  mult8_accumulator #(.ACC_W(17), .CNT_W(8)) dut17 (.clk(clk), .rst_n(rst_n), .bus(bus17));

  function automatic longint exp_sum(input int w);
    longint lim = longint'(1) << w;
`ifdef MULT8_ACC_SAT_EN
    return (m_sum >= lim) ? lim - 1 : m_sum;
`else
    return m_sum % lim;
`endif
  endfunction

  function automatic longint exp_ovf(input int w);
    return (m_sum >= (longint'(1) << w)) ? 1 : 0;
  endfunction

  function automatic longint exp_cnt();
    return (m_cnt > 255) ? 255 : m_cnt;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update at each clock edge from the frame rules
  always @(posedge clk) begin
    if (rst_n) begin
      if (acc_clr) begin
        m_sum = 0; m_cnt = 0; m_hold = 1'b0;
      end else if (!m_hold) begin
        if (in_valid) begin
          m_sum = m_sum + longint'(in_product);
          m_cnt = m_cnt + 1;
          if (in_last) m_hold = 1'b1;
        end
      end else if (out_ready) begin
        m_sum = 0; m_cnt = 0; m_hold = 1'b0;
      end
    end
  end

  // Asynchronous reset clears the model immediately
  always @(negedge rst_n) begin
    m_sum = 0; m_cnt = 0; m_hold = 1'b0;
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    #1;
    chk("in_ready24", longint'(bus24.in_ready), longint'(!m_hold && !acc_clr));
    chk("in_ready17", longint'(bus17.in_ready), longint'(!m_hold && !acc_clr));
    chk("out_valid24", longint'(bus24.out_valid), longint'(m_hold));
    chk("out_valid17", longint'(bus17.out_valid), longint'(m_hold));
    if (m_hold) begin
      chk("sum24", longint'(bus24.out_sum), exp_sum(24));
      chk("sum17", longint'(bus17.out_sum), exp_sum(17));
      chk("count24", longint'(bus24.out_count), exp_cnt());
      chk("count17", longint'(bus17.out_count), exp_cnt());
      chk("ovf24", longint'(bus24.out_ovf), exp_ovf(24));
      chk("ovf17", longint'(bus17.out_ovf), exp_ovf(17));
    end
  end

  task automatic beat(input logic [15:0] p, input logic l);
    @(negedge clk);
    in_valid = 1'b1; in_product = p; in_last = l; acc_clr = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_product = '0; in_last = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic release_result();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; acc_clr = 1'b0;
    out_ready = 1'b0; in_product = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset values
    @(negedge clk); #2;
    chk("rst_in_ready", longint'(bus24.in_ready), 1);
    chk("rst_out_valid", longint'(bus24.out_valid), 0);
    chk("rst_sum", longint'(bus24.out_sum), 0);
    chk("rst_count", longint'(bus24.out_count), 0);
    chk("rst_ovf", longint'(bus24.out_ovf), 0);

    // Three beats of 0xFE01; result valid the cycle after the last accept
    beat(16'hFE01, 1'b0);
    beat(16'hFE01, 1'b0);
    beat(16'hFE01, 1'b1);
    idle(); #2;
    chk("f1_valid", longint'(bus24.out_valid), 1);
    chk("f1_sum24", longint'(bus24.out_sum), 195075);
    chk("f1_count", longint'(bus24.out_count), 3);
    chk("f1_ovf24", longint'(bus24.out_ovf), 0);
`ifdef MULT8_ACC_SAT_EN
    chk("f1_sum17", longint'(bus17.out_sum), 131071);
`else
    chk("f1_sum17", longint'(bus17.out_sum), 64003);
`endif
    chk("f1_ovf17", longint'(bus17.out_ovf), 1);

    // Hold with out_ready low and beats offered: not accepted, outputs stable
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1; in_product = 16'($urandom); in_last = 1'($urandom);
      #2;
      chk("hold_in_ready", longint'(bus24.in_ready), 0);
      chk("hold_sum24", longint'(bus24.out_sum), 195075);
    end
    release_result();

    // Clean single-beat frame
    beat(16'd7, 1'b1);
    idle(); #2;
    chk("f2_sum", longint'(bus24.out_sum), 7);
    chk("f2_count", longint'(bus24.out_count), 1);
    release_result();

    // acc_clr coincident with a third beat: frame aborted, beat dropped
    beat(16'd1, 1'b0);
    beat(16'd1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_product = 16'd5; in_last = 1'b0; acc_clr = 1'b1;
    #2;
    chk("clr_in_ready", longint'(bus24.in_ready), 0);
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b1);
    idle(); #2;
    chk("f3_sum", longint'(bus24.out_sum), 3);
    chk("f3_count", longint'(bus24.out_count), 2);
    release_result();

    // Asynchronous reset during HOLD
    beat(16'd100, 1'b1);
    idle(); #2;
    chk("pre_rst_valid", longint'(bus24.out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", longint'(bus24.out_valid), 0);
    chk("arst_sum", longint'(bus24.out_sum), 0);
    chk("arst_count", longint'(bus24.out_count), 0);
    chk("arst_ovf", longint'(bus24.out_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #2;
    chk("post_rst_ready", longint'(bus24.in_ready), 1);

    // 300 beats of 1: count saturates at 255
    for (int i = 0; i < 300; i++) beat(16'd1, (i == 299));
    idle(); #2;
    chk("long_count", longint'(bus24.out_count), 255);
    chk("long_sum", longint'(bus24.out_sum), 300);
    chk("long_ovf", longint'(bus24.out_ovf), 0);
    release_result();

    // 300 beats of 0xFFFF: overflows the 24-bit accumulator too
    for (int i = 0; i < 300; i++) beat(16'hFFFF, (i == 299));
    idle(); #2;
    chk("big_ovf24", longint'(bus24.out_ovf), 1);
`ifdef MULT8_ACC_SAT_EN
    chk("big_sum24", longint'(bus24.out_sum), 16777215);
`else
    chk("big_sum24", longint'(bus24.out_sum), 2883284);
`endif
    release_result();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      in_valid   = ($urandom_range(0, 9) < 7);
      in_product = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      in_last    = ($urandom_range(0, 9) == 0);
      acc_clr    = ($urandom_range(0, 29) == 0);
      out_ready  = 1'($urandom);
    end
    idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
